// File: rtl/fifo_tx_serializer.sv
// ---------------------------------------------------------------------------
// fifo_tx_serializer
//
// Pops one word from a show-ahead FIFO and sends it as a UART-style serial
// frame: one start bit (0), WIDTH data bits LSB first, one stop bit (1).
// Every bit lasts CLKS_PER_BIT clock cycles. The line idles high.
//
// Handshake: the FIFO presents its head word on rdata whenever empty=0.
// shift_out is a one-cycle pop strobe. The word on rdata is consumed on the
// rising edge where shift_out=1. shift_out is only raised in IDLE with
// enable=1 and empty=0, so at most one pop happens per frame.
//
// Parameters
//   WIDTH         data word width in bits (>= 1)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   res_n        asynchronous active-low reset
//   enable       permission to start a new frame
//   empty        FIFO empty flag (1 = no word available)
//   rdata        FIFO head word
//   shift_out    FIFO pop strobe (combinational, one cycle)
//   tx           serial line (registered, idle high)
//   busy         high while a frame is in progress
//   frames_sent  number of completed frames (wraps at 16 bits)
//   state_dbg    current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
// ---------------------------------------------------------------------------
module fifo_tx_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             enable,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             shift_out,
    output logic             tx,
    output logic             busy,
    output logic [15:0]      frames_sent,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cyc_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] sh_q;
    logic             tx_q;
    logic             busy_q;
    logic [15:0]      frames_q;
    logic             bit_done;

    // Last cycle of the current start/data/stop bit.
    assign bit_done = (cyc_q == CYC_LAST);

    // res_n is included so the strobe stays low for the whole reset period,
    // not just after the first clock edge.
    assign shift_out = res_n && (state_q == IDLE) && enable && !empty;

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;
    assign state_dbg   = state_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (shift_out) begin
                        sh_q    <= rdata;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cyc_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        // The LSB moves onto the line and the register shifts
                        // at the same time. This keeps sh_q[0] as the next bit
                        // to send, which also works for WIDTH=1.
                        cyc_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cyc_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cyc_q    <= '0;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        frames_q <= frames_q + 16'd1;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
